mastermind_grader: RTL and testbench

MASTERMIND_GRADER -- requirements
Module: mastermind_grader

---
 rtl/mastermind_grader.sv | 255 +++++++++++++++++++++++++
 tb/tb_mastermind_grader.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_grader.sv
// Mastermind grader: scores a guess against a stored secret, reporting
// right-place (znarly) and wrong-place (zood) counts.
//
// Ports:
//   clock         in   rising-edge clock
//   reset_L       in   asynchronous active-low reset
//   masterPattern in   secret, taken on an accepted loadMaster
//   loadMaster    in   load secret and start a new game (IDLE only)
//   guess         in   guess, taken on an accepted gradeIt
//   gradeIt       in   start grading (IDLE, no win, no game over)
//   clearGame     in   synchronous abort/clear, highest priority
//   znarly        out  right shape, right position count
//   zood          out  right shape, wrong position count
//   gradeValid    out  one-cycle pulse when znarly/zood update
//   busy          out  grade in progress
//   roundNumber   out  completed grades this game
//   gameWon       out  sticky win flag
//   gameOver      out  round limit hit without a win
//
// Option: define GRADER_ROUND_LIMIT_EN to end the game after
// MAX_ROUNDS grades without a win; otherwise gameOver is 0 and
// roundNumber wraps.

module mastermind_grader #(
    parameter  int NUM_POS    = 4,
    parameter  int SHAPE_W    = 3,
    parameter  int MAX_ROUNDS = 8,
    localparam int PW         = NUM_POS * SHAPE_W,
    localparam int CW         = $clog2(NUM_POS + 1),
    localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic [PW-1:0] masterPattern,
    input  logic          loadMaster,
    input  logic [PW-1:0] guess,
    input  logic          gradeIt,
    input  logic          clearGame,
    output logic [CW-1:0] znarly,
    output logic [CW-1:0] zood,
    output logic          gradeValid,
    output logic          busy,
    output logic [RW-1:0] roundNumber,
    output logic          gameWon,
    output logic          gameOver
);

    localparam int S   = 1 << SHAPE_W;
    localparam int PCW = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        TALLY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]        secret_q, secret_d;
    logic [PW-1:0]        guess_q, guess_d;
    logic [PCW-1:0]       pos_q, pos_d;
    logic [SHAPE_W-1:0]   shp_q, shp_d;
    logic [S-1:0][CW-1:0] mhist_q, mhist_d;
    logic [S-1:0][CW-1:0] ghist_q, ghist_d;
    logic [CW-1:0]        hit_q, hit_d;
    logic [CW-1:0]        total_q, total_d;
    logic [CW-1:0]        znarly_q, znarly_d;
    logic [CW-1:0]        zood_q, zood_d;
    logic                 valid_q, valid_d;
    logic                 won_q, won_d;
    logic [RW-1:0]        round_q, round_d;
    logic                 over_w;

`ifdef GRADER_ROUND_LIMIT_EN
    logic over_q, over_d;
    assign over_w = over_q;
`else
    assign over_w = 1'b0;
`endif

    logic [SHAPE_W-1:0] m_sym, g_sym;
    logic [CW-1:0]      mh, gh, lo;

    // Shapes at the position currently being scanned
    always_comb begin
        m_sym = '0;
        g_sym = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (pos_q == PCW'(i)) begin
                m_sym = secret_q[i*SHAPE_W +: SHAPE_W];
                g_sym = guess_q[i*SHAPE_W +: SHAPE_W];
            end
        end
    end

    // Shapes matched regardless of position, for the shape in tally
    always_comb begin
        mh = mhist_q[shp_q];
        gh = ghist_q[shp_q];
        lo = (mh < gh) ? mh : gh;
    end

    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        guess_d  = guess_q;
        pos_d    = pos_q;
        shp_d    = shp_q;
        mhist_d  = mhist_q;
        ghist_d  = ghist_q;
        hit_d    = hit_q;
        total_d  = total_q;
        znarly_d = znarly_q;
        zood_d   = zood_q;
        valid_d  = 1'b0;
        won_d    = won_q;
        round_d  = round_q;
`ifdef GRADER_ROUND_LIMIT_EN
        over_d   = over_q;
`endif
        if (clearGame) begin
            state_d  = IDLE;
            pos_d    = '0;
            shp_d    = '0;
            mhist_d  = '0;
            ghist_d  = '0;
            hit_d    = '0;
            total_d  = '0;
            znarly_d = '0;
            zood_d   = '0;
            won_d    = 1'b0;
            round_d  = '0;
`ifdef GRADER_ROUND_LIMIT_EN
            over_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (loadMaster) begin
                        secret_d = masterPattern;
                        round_d  = '0;
                        znarly_d = '0;
                        zood_d   = '0;
                        won_d    = 1'b0;
`ifdef GRADER_ROUND_LIMIT_EN
                        over_d   = 1'b0;
`endif
                    end else if (gradeIt && !won_q && !over_w) begin
                        guess_d = guess;
                        pos_d   = '0;
                        mhist_d = '0;
                        ghist_d = '0;
                        hit_d   = '0;
                        total_d = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (m_sym == g_sym) begin
                        hit_d = hit_q + 1'b1;
                    end
                    mhist_d[m_sym] = mhist_q[m_sym] + 1'b1;
                    ghist_d[g_sym] = ghist_q[g_sym] + 1'b1;
                    pos_d = pos_q + 1'b1;
                    if (pos_q == PCW'(NUM_POS - 1)) begin
                        pos_d   = '0;
                        shp_d   = '0;
                        state_d = TALLY;
                    end
                end
                TALLY: begin
                    total_d = total_q + lo;
                    shp_d   = shp_q + 1'b1;
                    if (shp_q == SHAPE_W'(S - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    znarly_d = hit_q;
                    // total counts every shared shape, so the
                    // exact hits are removed to leave zood
                    zood_d   = total_q - hit_q;
                    valid_d  = 1'b1;
                    round_d  = round_q + 1'b1;
                    if (hit_q == CW'(NUM_POS)) begin
                        won_d = 1'b1;
                    end
`ifdef GRADER_ROUND_LIMIT_EN
                    else if (round_q == RW'(MAX_ROUNDS - 1)) begin
                        over_d = 1'b1;
                    end
`endif
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            secret_q <= '0;
            guess_q  <= '0;
            pos_q    <= '0;
            shp_q    <= '0;
            mhist_q  <= '0;
            ghist_q  <= '0;
            hit_q    <= '0;
            total_q  <= '0;
            znarly_q <= '0;
            zood_q   <= '0;
            valid_q  <= 1'b0;
            won_q    <= 1'b0;
            round_q  <= '0;
`ifdef GRADER_ROUND_LIMIT_EN
            over_q   <= 1'b0;
`endif
        end else begin
            secret_q <= secret_d;
            guess_q  <= guess_d;
            pos_q    <= pos_d;
            shp_q    <= shp_d;
            mhist_q  <= mhist_d;
            ghist_q  <= ghist_d;
            hit_q    <= hit_d;
            total_q  <= total_d;
            znarly_q <= znarly_d;
            zood_q   <= zood_d;
            valid_q  <= valid_d;
            won_q    <= won_d;
            round_q  <= round_d;
`ifdef GRADER_ROUND_LIMIT_EN
            over_q   <= over_d;
`endif
        end
    end

    assign znarly      = znarly_q;
    assign zood        = zood_q;
    assign gradeValid  = valid_q;
    assign busy        = (state_q != IDLE);
    assign roundNumber = round_q;
    assign gameWon     = won_q;
    assign gameOver    = over_w;

endmodule

// File: tb/tb_mastermind_grader.sv
// Bench for mastermind_grader: directed and random grading checked
// against a shape-counting reference model.

module tb_mastermind_grader;

    localparam int NP = 4;
    localparam int SW = 3;
    localparam int MR = 8;
    localparam int PW = NP * SW;
    localparam int CW = 3;
    localparam int RW = 4;
    localparam int S  = 8;
    localparam int LAT = NP + S + 1;

    logic          clock = 1'b0;
    logic          reset_L = 1'b1;
    logic [PW-1:0] masterPattern = '0;
    logic          loadMaster = 1'b0;
    logic [PW-1:0] guess = '0;
    logic          gradeIt = 1'b0;
    logic          clearGame = 1'b0;
    logic [CW-1:0] znarly, zood;
    logic          gradeValid, busy, gameWon, gameOver;
    logic [RW-1:0] roundNumber;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] m_secret = '0;
    int            m_round = 0;
    bit            m_won = 0;

    mastermind_grader dut (
        .clock(clock),
        .reset_L(reset_L),
        .masterPattern(masterPattern),
        .loadMaster(loadMaster),
        .guess(guess),
        .gradeIt(gradeIt),
        .clearGame(clearGame),
        .znarly(znarly),
        .zood(zood),
        .gradeValid(gradeValid),
        .busy(busy),
        .roundNumber(roundNumber),
        .gameWon(gameWon),
        .gameOver(gameOver)
    );

    always #5 clock = ~clock;

    function automatic logic [PW-1:0] pat(input int a3, a2, a1, a0);
        logic [PW-1:0] r;
        r[3*SW +: SW] = SW'(a3);
        r[2*SW +: SW] = SW'(a2);
        r[1*SW +: SW] = SW'(a1);
        r[0*SW +: SW] = SW'(a0);
        return r;
    endfunction

    function automatic logic [PW-1:0] rnd_pat(input int lim);
        logic [PW-1:0] r;
        for (int i = 0; i < NP; i++)
            r[i*SW +: SW] = SW'($urandom_range(0, lim));
        return r;
    endfunction

    // Game rules: exact hits, plus shared shapes counted via histograms
    function automatic void ref_grade(input logic [PW-1:0] m,
                                      input logic [PW-1:0] g,
                                      output int zn, output int zd);
        int mc[S];
        int gc[S];
        int tot;
        for (int k = 0; k < S; k++) begin
            mc[k] = 0;
            gc[k] = 0;
        end
        zn = 0;
        for (int i = 0; i < NP; i++) begin
            int a, b;
            a = int'(m[i*SW +: SW]);
            b = int'(g[i*SW +: SW]);
            if (a == b) zn++;
            mc[a]++;
            gc[b]++;
        end
        tot = 0;
        for (int k = 0; k < S; k++)
            tot += (mc[k] < gc[k]) ? mc[k] : gc[k];
        zd = tot - zn;
    endfunction

    // All tasks start and end just after a falling edge
    task automatic load_master(input logic [PW-1:0] p);
        masterPattern = p;
        loadMaster = 1'b1;
        @(negedge clock);
        loadMaster = 1'b0;
        m_secret = p;
        m_round = 0;
        m_won = 0;
    endtask

    task automatic run_grade(input logic [PW-1:0] g, output int lat,
                             output logic [CW-1:0] z,
                             output logic [CW-1:0] zo,
                             output logic b1);
        guess = g;
        gradeIt = 1'b1;
        lat = -1;
        z = '0;
        zo = '0;
        b1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            gradeIt = 1'b0;
            if (c == 1) b1 = busy;
            if (gradeValid) begin
                lat = c - 1;
                z = znarly;
                zo = zood;
                break;
            end
        end
    endtask

    task automatic watch_idle(input int n, input bit pulse,
                              output int bc, output int vc);
        bc = 0;
        vc = 0;
        if (pulse) gradeIt = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            gradeIt = 1'b0;
            bc += int'(busy);
            vc += int'(gradeValid);
        end
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset_L = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if ({znarly, zood, gradeValid, busy, roundNumber,
             gameWon, gameOver} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {znarly, zood, gradeValid, busy, roundNumber,
                      gameWon, gameOver});
        end
        reset_L = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || roundNumber !== '0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b round=%0d, expected 0/0",
                     busy, roundNumber);
        end
    endtask

    task automatic test_directed;
        int lat;
        logic [CW-1:0] z, zo;
        logic b1;
        load_master(pat(4, 3, 2, 1));
        run_grade(pat(3, 4, 2, 1), lat, z, zo, b1);
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++;
            $display("FAIL dir_latency: got %0d, expected %0d", lat, LAT);
        end
        n_cmp++;
        if (b1 !== 1'b1) begin
            n_bad++;
            $display("FAIL dir_busy: got %b, expected 1", b1);
        end
        n_cmp++;
        if (z !== 3'd2 || zo !== 3'd2 || roundNumber !== 4'd1) begin
            n_bad++;
            $display("FAIL dir_4321: got z=%0d zo=%0d r=%0d, expected 2/2/1",
                     z, zo, roundNumber);
        end
        @(negedge clock);
        n_cmp++;
        if (gradeValid !== 1'b0 || znarly !== 3'd2) begin
            n_bad++;
            $display("FAIL dir_pulse_hold: got v=%b z=%0d, expected 0/2",
                     gradeValid, znarly);
        end
        load_master(pat(2, 2, 1, 1));
        run_grade(pat(5, 1, 2, 1), lat, z, zo, b1);
        n_cmp++;
        if (z !== 3'd1 || zo !== 3'd2) begin
            n_bad++;
            $display("FAIL dir_2211a: got z=%0d zo=%0d, expected 1/2",
                     z, zo);
        end
        run_grade(pat(5, 5, 5, 5), lat, z, zo, b1);
        n_cmp++;
        if (z !== 3'd0 || zo !== 3'd0 || roundNumber !== 4'd2) begin
            n_bad++;
            $display("FAIL dir_2211b: got z=%0d zo=%0d r=%0d, expected 0/0/2",
                     z, zo, roundNumber);
        end
        m_round = 2;
    endtask

    task automatic test_random;
        int lat, ez, ezo;
        logic [CW-1:0] z, zo;
        logic b1;
        logic [PW-1:0] g;
        for (int gm = 0; gm < 12; gm++) begin
            load_master(rnd_pat(($urandom_range(0, 1) == 1) ? 7 : 2));
            for (int k = 0; k < 3; k++) begin
                if (k == 2 && gm % 3 == 0) g = m_secret;
                else g = rnd_pat(($urandom_range(0, 1) == 1) ? 7 : 2);
                ref_grade(m_secret, g, ez, ezo);
                run_grade(g, lat, z, zo, b1);
                m_round++;
                if (ez == NP) m_won = 1;
                n_cmp++;
                if (lat !== LAT || int'(z) !== ez || int'(zo) !== ezo) begin
                    n_bad++;
                    $display("FAIL rand_grade: got lat=%0d z=%0d zo=%0d, expected %0d/%0d/%0d",
                             lat, z, zo, LAT, ez, ezo);
                end
                n_cmp++;
                if (int'(roundNumber) !== m_round || gameWon !== m_won) begin
                    n_bad++;
                    $display("FAIL rand_state: got r=%0d w=%b, expected %0d/%b",
                             roundNumber, gameWon, m_round, m_won);
                end
                if (m_won) break;
            end
        end
    endtask

    task automatic test_win;
        int lat, bc, vc;
        logic [CW-1:0] z, zo;
        logic b1;
        load_master(pat(6, 0, 7, 3));
        run_grade(pat(6, 0, 7, 3), lat, z, zo, b1);
        n_cmp++;
        if (z !== 3'd4 || zo !== 3'd0 || gameWon !== 1'b1) begin
            n_bad++;
            $display("FAIL win_grade: got z=%0d zo=%0d w=%b, expected 4/0/1",
                     z, zo, gameWon);
        end
        watch_idle(20, 1'b1, bc, vc);
        n_cmp++;
        if (bc !== 0 || vc !== 0 || roundNumber !== 4'd1) begin
            n_bad++;
            $display("FAIL win_ignore: got busy=%0d valid=%0d r=%0d, expected 0/0/1",
                     bc, vc, roundNumber);
        end
    endtask

    task automatic test_busy_ignore;
        int vc, lat;
        load_master(pat(1, 2, 3, 4));
        guess = pat(4, 3, 2, 1);
        gradeIt = 1'b1;
        vc = 0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c < LAT + 1) begin
                gradeIt = 1'($urandom_range(0, 1));
                guess = rnd_pat(7);
            end else begin
                gradeIt = 1'b0;
            end
            if (gradeValid) begin
                vc++;
                if (lat < 0) lat = c - 1;
            end
        end
        n_cmp++;
        if (vc !== 1 || lat !== LAT) begin
            n_bad++;
            $display("FAIL busy_pulses: got n=%0d lat=%0d, expected 1/%0d",
                     vc, lat, LAT);
        end
        n_cmp++;
        if (znarly !== 3'd0 || zood !== 3'd4 || roundNumber !== 4'd1) begin
            n_bad++;
            $display("FAIL busy_result: got z=%0d zo=%0d r=%0d, expected 0/4/1",
                     znarly, zood, roundNumber);
        end
    endtask

    task automatic test_load_priority;
        int lat;
        logic [CW-1:0] z, zo;
        logic b1;
        masterPattern = pat(7, 7, 7, 7);
        guess = pat(7, 7, 7, 7);
        loadMaster = 1'b1;
        gradeIt = 1'b1;
        @(negedge clock);
        loadMaster = 1'b0;
        gradeIt = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || zood !== 3'd0 || roundNumber !== 4'd0) begin
            n_bad++;
            $display("FAIL load_prio: got busy=%b zo=%0d r=%0d, expected 0/0/0",
                     busy, zood, roundNumber);
        end
        run_grade(pat(7, 7, 0, 0), lat, z, zo, b1);
        n_cmp++;
        if (z !== 3'd2 || zo !== 3'd0) begin
            n_bad++;
            $display("FAIL load_secret: got z=%0d zo=%0d, expected 2/0",
                     z, zo);
        end
    endtask

    task automatic test_clear;
        int lat, bc, vc;
        logic [CW-1:0] z, zo;
        logic b1;
        load_master(pat(1, 1, 2, 2));
        run_grade(pat(2, 1, 3, 3), lat, z, zo, b1);
        n_cmp++;
        if (z !== 3'd1 || zo !== 3'd1) begin
            n_bad++;
            $display("FAIL clear_pre: got z=%0d zo=%0d, expected 1/1",
                     z, zo);
        end
        guess = pat(2, 1, 3, 3);
        gradeIt = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            gradeIt = 1'b0;
        end
        clearGame = 1'b1;
        gradeIt = 1'b1;
        @(negedge clock);
        clearGame = 1'b0;
        gradeIt = 1'b0;
        n_cmp++;
        if ({busy, gradeValid, znarly, zood, roundNumber, gameWon}
            !== '0) begin
            n_bad++;
            $display("FAIL clear_state: got %h, expected 0",
                     {busy, gradeValid, znarly, zood, roundNumber,
                      gameWon});
        end
        watch_idle(20, 1'b0, bc, vc);
        n_cmp++;
        if (bc !== 0 || vc !== 0) begin
            n_bad++;
            $display("FAIL clear_quiet: got busy=%0d valid=%0d, expected 0/0",
                     bc, vc);
        end
        run_grade(pat(1, 1, 2, 2), lat, z, zo, b1);
        n_cmp++;
        if (z !== 3'd4 || gameWon !== 1'b1 || roundNumber !== 4'd1) begin
            n_bad++;
            $display("FAIL clear_keep: got z=%0d w=%b r=%0d, expected 4/1/1",
                     z, gameWon, roundNumber);
        end
    endtask

    task automatic test_rounds;
        int lat, bc, vc;
        logic [CW-1:0] z, zo;
        logic b1;
        load_master(pat(0, 1, 2, 3));
        for (int r = 1; r <= MR; r++) begin
            run_grade(pat(7, 7, 7, 7), lat, z, zo, b1);
            n_cmp++;
            if (lat !== LAT || int'(roundNumber) !== r || z !== 3'd0) begin
                n_bad++;
                $display("FAIL round_step: got lat=%0d r=%0d z=%0d, expected %0d/%0d/0",
                         lat, roundNumber, z, LAT, r);
            end
        end
`ifdef GRADER_ROUND_LIMIT_EN
        n_cmp++;
        if (gameOver !== 1'b1) begin
            n_bad++;
            $display("FAIL round_over: got %b, expected 1", gameOver);
        end
        watch_idle(20, 1'b1, bc, vc);
        n_cmp++;
        if (bc !== 0 || vc !== 0 || roundNumber !== 4'd8) begin
            n_bad++;
            $display("FAIL round_ignore: got busy=%0d valid=%0d r=%0d, expected 0/0/8",
                     bc, vc, roundNumber);
        end
`else
        n_cmp++;
        if (gameOver !== 1'b0) begin
            n_bad++;
            $display("FAIL round_over: got %b, expected 0", gameOver);
        end
        bc = 0;
        vc = 0;
        run_grade(pat(7, 7, 7, 7), lat, z, zo, b1);
        n_cmp++;
        if (lat !== LAT || roundNumber !== 4'd9) begin
            n_bad++;
            $display("FAIL round_ninth: got lat=%0d r=%0d, expected %0d/9",
                     lat, roundNumber, LAT);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int lat, bc, vc;
        logic [CW-1:0] z, zo;
        logic b1;
        load_master(pat(3, 3, 3, 3));
        run_grade(pat(3, 0, 0, 0), lat, z, zo, b1);
        guess = pat(3, 3, 0, 0);
        gradeIt = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            gradeIt = 1'b0;
        end
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if ({busy, gradeValid, znarly, zood, roundNumber, gameWon,
             gameOver} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: got %h, expected 0",
                     {busy, gradeValid, znarly, zood, roundNumber,
                      gameWon, gameOver});
        end
        @(negedge clock);
        reset_L = 1'b1;
        watch_idle(20, 1'b0, bc, vc);
        n_cmp++;
        if (bc !== 0 || vc !== 0) begin
            n_bad++;
            $display("FAIL rst_quiet: got busy=%0d valid=%0d, expected 0/0",
                     bc, vc);
        end
        run_grade(pat(0, 0, 0, 0), lat, z, zo, b1);
        n_cmp++;
        if (lat !== LAT || z !== 3'd4 || roundNumber !== 4'd1) begin
            n_bad++;
            $display("FAIL rst_secret: got lat=%0d z=%0d r=%0d, expected %0d/4/1",
                     lat, z, roundNumber, LAT);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_win;
        test_busy_ignore;
        test_load_priority;
        test_clear;
        test_rounds;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
